// File: rtl/ttl_event_scheduler.sv
// Timed TTL sequencer: (time, value) events queue in a circular FIFO; the head drives ttl_out one edge after timestamp reaches its time.
// Pushes are accepted while not full and dropped with a sticky overflow flag otherwise; stale heads are released immediately with a sticky late flag.
module ttl_event_scheduler #(
  parameter int TIME_WIDTH = 64,
  parameter int TTL_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  event_wr_en,
  input  logic [TIME_WIDTH-1:0] event_time,
  input  logic [TTL_WIDTH-1:0]  event_value,
  output logic                  event_full,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  input  logic                  ctrl_start,
  input  logic                  ctrl_stop,
  input  logic                  ctrl_flush,
  input  logic                  err_clear,
  output logic                  running,
  output logic [TIME_WIDTH-1:0] timestamp,
  output logic [TTL_WIDTH-1:0]  ttl_out,
  output logic                  late_error,
  output logic                  overflow_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] LP_DEPTH = CNT_WIDTH'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  typedef struct packed {
    logic [TIME_WIDTH-1:0] t;
    logic [TTL_WIDTH-1:0]  v;
  } ev_t;

  state_t                r_state;
  state_t                w_state_nxt;
  ev_t                   r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [TIME_WIDTH-1:0] r_timestamp;
  logic [TTL_WIDTH-1:0]  r_ttl;
  logic                  r_late;
  logic                  r_ovf;

  ev_t  w_head;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_drop;
  logic w_pop;
  logic w_late;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fullness is taken from the registered count, so a pop in the same cycle cannot make room.
  always_comb begin
    w_state_nxt = r_state;
    w_head      = r_mem[r_rd_ptr];
    w_full      = (r_count == LP_DEPTH);
    w_empty     = (r_count == '0);
    w_push      = event_wr_en && !w_full && !ctrl_flush;
    w_drop      = event_wr_en && w_full && !ctrl_flush;
    w_pop       = 1'b0;
    w_late      = 1'b0;
    if (ctrl_flush) begin
      w_state_nxt = ST_IDLE;
    end else if (ctrl_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (ctrl_start) begin
      w_state_nxt = ST_RUN;
    end
    if ((r_state == ST_RUN) && !ctrl_flush && !w_empty && (w_head.t <= r_timestamp)) begin
      w_pop  = 1'b1;
      w_late = (w_head.t < r_timestamp);
    end
  end

  // Storage is not reset: the pointers and count define which entries are live.
  always_ff @(posedge s_axi_aclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {event_time, event_value};
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_timestamp <= '0;
      r_ttl       <= '0;
      r_late      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (ctrl_flush) begin
        r_timestamp <= '0;
      end else if (r_state == ST_RUN) begin
        r_timestamp <= r_timestamp + TIME_WIDTH'(1);
      end

      if (w_pop) begin
        r_ttl <= w_head.v;
      end

      if (ctrl_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_WIDTH'(1);
          2'b01:   r_count <= r_count - CNT_WIDTH'(1);
          default: r_count <= r_count;
        endcase
      end

      // A new error in the same cycle as a clear wins.
      r_late <= w_late | (r_late & ~err_clear);
      r_ovf  <= w_drop | (r_ovf & ~err_clear);
    end
  end

  assign event_full     = w_full;
  assign fifo_count     = r_count;
  assign running        = (r_state == ST_RUN);
  assign timestamp      = r_timestamp;
  assign ttl_out        = r_ttl;
  assign late_error     = r_late;
  assign overflow_error = r_ovf;

endmodule

// File: doc/ttl_event_scheduler.md
# ttl_event_scheduler

Timed TTL sequencer that owns the 32-bit TTL output bank and drives it at pre-programmed timestamps. Host-side AXI logic pushes (time, value) events into an internal FIFO. A free-running timestamp counter releases each event onto `ttl_out` when its time arrives. Start, stop and flush are software controls; late and overflow conditions are reported through sticky error flags.

## Interface
- `TIME_WIDTH`, 64, timestamp and event-time width
- `TTL_WIDTH`, 32, TTL output width
- `FIFO_DEPTH`, 16, event FIFO entries (power of two, ≥2)
- `CNT_WIDTH`, $clog2(FIFO_DEPTH)+1, occupancy width

Ports:
- `s_axi_aclk` in 1 — single clock
- `s_axi_aresetn` in 1 — reset, asynchronous, active-low
- `event_wr_en` in 1 — push request
- `event_time` in TIME_WIDTH — event release time
- `event_value` in TTL_WIDTH — TTL value to apply
- `event_full` out 1 — FIFO full, combinational from count
- `fifo_count` out CNT_WIDTH — occupancy, registered
- `ctrl_start` in 1 — pulse, begin/resume counting
- `ctrl_stop` in 1 — pulse, pause counting
- `ctrl_flush` in 1 — pulse, drop events, zero timestamp, go idle
- `err_clear` in 1 — pulse, clear sticky errors
- `running` out 1 — 1 in RUN state
- `timestamp` out TIME_WIDTH — current counter value
- `ttl_out` out TTL_WIDTH — registered TTL outputs
- `late_error` out 1 — sticky, an event was released after its time
- `overflow_error` out 1 — sticky, a push was dropped

## Operation
- Reset values: state IDLE, `running` 0, `timestamp` 0, `ttl_out` 0, `fifo_count` 0, `event_full` 0, both errors 0, FIFO empty.
- States:
  - IDLE: counter holds; no pops.
  - RUN: counter increments by 1 every cycle; head event evaluated every cycle.
- Transitions: IDLE→RUN on `ctrl_start`; RUN→IDLE on `ctrl_stop`; any→IDLE on `ctrl_flush`.
- Control priority when asserted together: flush > stop > start.
- Push: accepted when `event_wr_en && !event_full`.
  - Fullness is evaluated before the same-cycle pop, so a push at full is dropped even if a pop occurs.
  - A dropped push sets `overflow_error`.
  - Push in a flush cycle: dropped, no error.
- Release, RUN only, non-empty FIFO, head time H, current timestamp T:
  - H == T: `ttl_out` ← head value, pop.
  - H < T (unsigned): `ttl_out` ← head value, pop, set `late_error`.
  - H > T: hold.
  - At most one pop per cycle. Several events with equal time release on consecutive cycles; all after the first flag late.
- Timestamp wraps modulo 2^TIME_WIDTH. Comparison is plain unsigned; events beyond the wrap are the host's responsibility.
- Flush:
  - empties FIFO and zeroes timestamp;
  - `ttl_out` keeps its last value;
  - errors are unaffected.
- Errors:
  - sticky until `err_clear`;
  - a same-cycle set beats clear.
- FIFO: circular buffer with read/write pointers; `fifo_count` tracks push and pop in the same cycle (net 0).

## Timing
- Push to visible: `fifo_count` rises 1 cycle after an accepted push. Head is eligible for release on the following cycle.
- Release: in the cycle where `timestamp`==H, `ttl_out` takes the new value at the next edge. That edge is the same one at which `timestamp` becomes H+1.
- `running` and the counter:
  - `running` goes to 1 at the edge that samples `ctrl_start`;
  - first increment occurs at the next edge;
  - stop freezes the counter at the edge sampling `ctrl_stop` (the value from that edge is held).
- Async reset mid-run: all state returns to reset values immediately and the FIFO contents are discarded. Operation resumes only after deassertion plus `ctrl_start`.

## Test plan
- Basic sequence:
  - Stimulus: push (5, 0x1), (8, 0x3), (8, 0x7); start at T=0.
  - Required: `ttl_out`=0x1 when `timestamp`=6; 0x3 at 9; 0x7 at 10; `late_error`=1 after the third event; `fifo_count` returns to 0.
- Late event:
  - Stimulus: run to T=20, stop; push (10, 0xAA); start.
  - Required: `ttl_out`=0xAA one cycle after start; `late_error`=1; `err_clear` returns it to 0.
- Overflow:
  - Stimulus: with the scheduler idle, push 17 events (FIFO_DEPTH=16).
  - Required: `event_full`=1 after 16; 17th dropped; `overflow_error`=1; `fifo_count`=16.
- Pause/resume:
  - Stimulus: push (30, 0x5); start; stop at T=12; wait 50 cycles; start.
  - Required: `timestamp` holds 12 while stopped; `ttl_out`=0x5 when `timestamp`=31.
- Flush mid-run:
  - Stimulus: 4 queued events, T=7, `ttl_out`=0x2; assert flush together with start.
  - Required: IDLE, `timestamp`=0, `fifo_count`=0, `ttl_out` still 0x2, `running`=0.
- Reset mid-run:
  - Stimulus: assert `s_axi_aresetn`=0 asynchronously between edges while events are pending.
  - Required: all outputs at reset values before the next edge; no releases after deassertion until start.
